sync_generator: RTL and testbench
=================================

# sync_generator

Video timing source that produces the beat stream consumed by `location_generator`: a beat strobe plus `hsync`/`vsync` markers, emitted in exactly the order that keeps the receiver's (x, y, frame) counters coherent. It sits at the head of the pixel pipeline, driving test patterns and replayed frames, and runs frame by frame under a `run` control. It also exports its own pixel coordinates and frame count so that a bench or checker can compare them against the receiver's.

## Interface
Parameters:
- WIDTH, 640, pixel beats per row; legal values are 1 and above.
- HEIGHT, 480, rows per frame; legal values are 1 and above.
- H_BLANK, 0, silent `en` cycles after each hsync beat; legal values are 0 and above.
- V_BLANK, 0, silent `en` cycles after each vsync beat; legal values are 0 and above.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  advance qualifier; the FSM steps only on rising edges where en=1.
- run  input  1  start/continue frames; sampled in IDLE and at frame end.
- stb  output  1  one-cycle beat strobe; drives the receiver's `en`.
- hsync  output  1  end-of-row beat; 0 whenever stb=0.
- vsync  output  1  end-of-frame beat; 0 whenever stb=0.
- de  output  1  pixel beat; 0 whenever stb=0.
- x  output  32  column of the last pixel beat.
- y  output  32  row of the last pixel beat.
- frame  output  32  count of vsync beats emitted, including the one currently visible.
- busy  output  1  1 whenever state ≠ IDLE.

## Operation
- All outputs are registered. On reset, every output is 0 and the state is IDLE.
- The state names the next beat to emit. On each clk edge with en=1, the current state emits its beat, which is visible on the outputs for exactly the following cycle. It then transitions.
- On edges with en=0, stb/hsync/vsync/de go to 0, the state holds, and x/y/frame hold.
- Exactly one of de/hsync/vsync is 1 when stb=1. hsync and vsync are never asserted together, because the receiver gives hsync priority.

States and transitions:
- IDLE: emits nothing. If run=1, go to ACTIVE with the column and row counters at 0. No beat is emitted on this edge.
- ACTIVE: emits a pixel beat with de=1, x=col, y=row. If col=WIDTH-1, go to HSYNC; otherwise col+1.
- HSYNC: emits an hsync beat.
  - If H_BLANK>0, go to HBLANK and load the blank counter.
  - Otherwise go to the row-advance step.
- HBLANK: emits nothing. After H_BLANK en-cycles, take the row-advance step.
- Row-advance step: if row=HEIGHT-1, go to VSYNC; otherwise row+1, col=0, go to ACTIVE.
- VSYNC: emits a vsync beat and increments frame, so the new value is visible with the beat. Row and col clear.
  - If V_BLANK>0, go to VBLANK.
  - Otherwise, go to ACTIVE if run=1, else IDLE.
- VBLANK: emits nothing. After V_BLANK en-cycles, go to ACTIVE if run=1, else IDLE.

Other rules:
- x and y are not updated on hsync, vsync or blank beats; they keep the last pixel's values.
- A frame costs HEIGHT·(WIDTH+1+H_BLANK)+1+V_BLANK en-cycles.

## Timing
- Latency: a beat appears one cycle after the en edge that emitted it. The first pixel appears two en-edges after run is seen in IDLE.
- Deasserting run mid-frame has no effect until the frame ends; the frame completes, including V_BLANK.
- run=1 at frame end starts the next frame back-to-back, with no IDLE cycle.
- en may drop in any state, including blanks; the blank counters count only en=1 cycles.
- frame wraps from 2^32-1 to 0.
- col and row are internal counters sized to 32 bits; x and y are their copies.
- Asserting reset_n low during any state forces IDLE and all outputs to 0 immediately, without waiting for clk. The next frame after release starts at (0,0) with frame=0.
- With WIDTH=1, every row is one pixel beat followed by an hsync beat. With HEIGHT=1, the hsync beat is followed directly by vsync (or by H_BLANK and then vsync).

## Test plan
- WIDTH=4, HEIGHT=2, blanks 0, en=1, run held for 1 frame then dropped:
  - Beats are px(0,0)…(3,0), H, px(0,1)…(3,1), H, V, then IDLE.
  - frame=1 and busy=0 afterwards.
  - A receiver driven by stb/hsync/vsync ends at x=0, y=0, frame=1.
- H_BLANK=1, V_BLANK=2, same size, run continuous: the period is 15 en-cycles, stb is low on each blank, and frame=2 at the second vsync.
- en toggling 1,0 every cycle: the beat order is identical to the first case, stb is never high on two consecutive cycles, and blank lengths still count en-cycles.
- run dropped during row 0 of frame 0: the frame finishes through V, then IDLE. Raising run again restarts at px(0,0) with frame continuing from 1.
- reset_n pulsed low mid-row at x=2: all outputs are 0 asynchronously. After release with run=1, the first pixel is (0,0) and frame=0 before the first V.
- WIDTH=1, HEIGHT=1: the beat sequence is px(0,0), H, V, repeating, and hsync and vsync are never both high.

Source files
------------

// File: rtl/sync_generator.sv
// Video timing source: pixel/hsync/vsync beat stream with exported (x, y, frame).
// Latency: each beat is registered and visible the cycle after the en edge that emitted it.
// Backpressure: en=0 freezes the state, counters and blank timers; stb drops to 0 meanwhile.
module sync_generator #(
   parameter int WIDTH   = 640,
   parameter int HEIGHT  = 480,
   parameter int H_BLANK = 0,
   parameter int V_BLANK = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        en,
   input  logic        run,
   output logic        stb,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [31:0] x,
   output logic [31:0] y,
   output logic [31:0] frame,
   output logic        busy
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ACTIVE = 3'd1;
   localparam logic [2:0] S_HSYNC  = 3'd2;
   localparam logic [2:0] S_HBLANK = 3'd3;
   localparam logic [2:0] S_VSYNC  = 3'd4;
   localparam logic [2:0] S_VBLANK = 3'd5;

   localparam logic [31:0] LAST_COL = 32'(WIDTH - 1);
   localparam logic [31:0] LAST_ROW = 32'(HEIGHT - 1);
   // Blank timers count down to zero, so they are loaded with length-1.
   localparam logic [31:0] H_LOAD   = 32'((H_BLANK > 0) ? H_BLANK - 1 : 0);
   localparam logic [31:0] V_LOAD   = 32'((V_BLANK > 0) ? V_BLANK - 1 : 0);

   logic [2:0]  state, state_nxt;
   logic [31:0] col, col_nxt;
   logic [31:0] row, row_nxt;
   logic [31:0] blank_cnt, blank_nxt;
   logic [31:0] x_nxt, y_nxt, frame_nxt;
   logic        stb_nxt, hsync_nxt, vsync_nxt, de_nxt;
   logic        row_advance, frame_end;

   // Next-state and next-beat decode; the state names the beat emitted on the next en edge.
   always_comb begin
      state_nxt   = state;
      col_nxt     = col;
      row_nxt     = row;
      blank_nxt   = blank_cnt;
      x_nxt       = x;
      y_nxt       = y;
      frame_nxt   = frame;
      stb_nxt     = 1'b0;
      hsync_nxt   = 1'b0;
      vsync_nxt   = 1'b0;
      de_nxt      = 1'b0;
      row_advance = 1'b0;
      frame_end   = 1'b0;
      if (en) begin
         case (state)
            S_IDLE: begin
               if (run) begin
                  state_nxt = S_ACTIVE;
                  col_nxt   = '0;
                  row_nxt   = '0;
               end
            end
            S_ACTIVE: begin
               stb_nxt = 1'b1;
               de_nxt  = 1'b1;
               x_nxt   = col;
               y_nxt   = row;
               if (col == LAST_COL) state_nxt = S_HSYNC;
               else                 col_nxt   = col + 32'd1;
            end
            S_HSYNC: begin
               stb_nxt   = 1'b1;
               hsync_nxt = 1'b1;
               if (H_BLANK > 0) begin
                  state_nxt = S_HBLANK;
                  blank_nxt = H_LOAD;
               end else begin
                  row_advance = 1'b1;
               end
            end
            S_HBLANK: begin
               if (blank_cnt == '0) row_advance = 1'b1;
               else                 blank_nxt   = blank_cnt - 32'd1;
            end
            S_VSYNC: begin
               stb_nxt   = 1'b1;
               vsync_nxt = 1'b1;
               frame_nxt = frame + 32'd1;
               col_nxt   = '0;
               row_nxt   = '0;
               if (V_BLANK > 0) begin
                  state_nxt = S_VBLANK;
                  blank_nxt = V_LOAD;
               end else begin
                  frame_end = 1'b1;
               end
            end
            S_VBLANK: begin
               if (blank_cnt == '0) frame_end = 1'b1;
               else                 blank_nxt = blank_cnt - 32'd1;
            end
            default: state_nxt = S_IDLE;
         endcase
         // Shared row-advance step, reached from HSYNC or the end of HBLANK.
         if (row_advance) begin
            if (row == LAST_ROW) begin
               state_nxt = S_VSYNC;
            end else begin
               row_nxt   = row + 32'd1;
               col_nxt   = '0;
               state_nxt = S_ACTIVE;
            end
         end
         // run is only honoured here, so a frame always completes once started.
         if (frame_end) state_nxt = run ? S_ACTIVE : S_IDLE;
      end
   end

   // State, counters and registered outputs; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         col       <= '0;
         row       <= '0;
         blank_cnt <= '0;
         stb       <= 1'b0;
         hsync     <= 1'b0;
         vsync     <= 1'b0;
         de        <= 1'b0;
         x         <= '0;
         y         <= '0;
         frame     <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         col       <= col_nxt;
         row       <= row_nxt;
         blank_cnt <= blank_nxt;
         stb       <= stb_nxt;
         hsync     <= hsync_nxt;
         vsync     <= vsync_nxt;
         de        <= de_nxt;
         x         <= x_nxt;
         y         <= y_nxt;
         frame     <= frame_nxt;
         busy      <= (state_nxt != S_IDLE);
      end
   end

endmodule

// File: tb/tb_sync_generator.sv
// Directed bench for sync_generator: beat order, blanking period, en gaps, run drop, async reset.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: en toggling exercised on the 4x2 and blanked instances.
module tb_sync_generator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: 4x2, no blanking.
   logic a_rst_n, a_en, a_run, a_stb, a_hs, a_vs, a_de, a_busy;
   logic [31:0] a_x, a_y, a_frame;
   // Instance B: 4x2, H_BLANK=1, V_BLANK=2.
   logic b_rst_n, b_en, b_run, b_stb, b_hs, b_vs, b_de, b_busy;
   logic [31:0] b_x, b_y, b_frame;
   // Instance C: 1x1, no blanking.
   logic c_rst_n, c_en, c_run, c_stb, c_hs, c_vs, c_de, c_busy;
   logic [31:0] c_x, c_y, c_frame;

   sync_generator #(.WIDTH(4), .HEIGHT(2), .H_BLANK(0), .V_BLANK(0)) u_a (
      .clk(clk), .reset_n(a_rst_n), .en(a_en), .run(a_run), .stb(a_stb), .hsync(a_hs),
      .vsync(a_vs), .de(a_de), .x(a_x), .y(a_y), .frame(a_frame), .busy(a_busy));
   sync_generator #(.WIDTH(4), .HEIGHT(2), .H_BLANK(1), .V_BLANK(2)) u_b (
      .clk(clk), .reset_n(b_rst_n), .en(b_en), .run(b_run), .stb(b_stb), .hsync(b_hs),
      .vsync(b_vs), .de(b_de), .x(b_x), .y(b_y), .frame(b_frame), .busy(b_busy));
   sync_generator #(.WIDTH(1), .HEIGHT(1), .H_BLANK(0), .V_BLANK(0)) u_c (
      .clk(clk), .reset_n(c_rst_n), .en(c_en), .run(c_run), .stb(c_stb), .hsync(c_hs),
      .vsync(c_vs), .de(c_de), .x(c_x), .y(c_y), .frame(c_frame), .busy(c_busy));

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Beat code: 1=pixel, 2=hsync, 3=vsync, 7=illegal marker combination; packed with x, y.
   function automatic logic [31:0] beat(input logic de, input logic hs, input logic vs,
                                        input logic [31:0] bx, input logic [31:0] by);
      logic [3:0] code;
      case ({de, hs, vs})
         3'b100:  code = 4'd1;
         3'b010:  code = 4'd2;
         3'b001:  code = 4'd3;
         default: code = 4'd7;
      endcase
      return {12'h000, code, bx[7:0], by[7:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hand-derived beat sequence for one 4x2 frame.
   logic [31:0] exp_a [11] = '{32'h10000, 32'h10100, 32'h10200, 32'h10300, 32'h20300,
                               32'h10001, 32'h10101, 32'h10201, 32'h10301, 32'h20301,
                               32'h30301};
   // Hand-derived 1x1 sequence, three frames.
   logic [31:0] exp_c [9] = '{32'h10000, 32'h20000, 32'h30000,
                              32'h10000, 32'h20000, 32'h30000,
                              32'h10000, 32'h20000, 32'h30000};

   logic [31:0] a_q[$];
   int a_consec;
   int rx_x, rx_y, rx_f;

   // Run instance A for ncyc cycles, recording beats and a model receiver's counters.
   task automatic collect_a(input int ncyc, input bit toggle, input bit drop_run);
      logic prev;
      prev = 1'b0;
      a_q.delete();
      a_consec = 0;
      rx_x = 0; rx_y = 0; rx_f = 0;
      for (int i = 0; i < ncyc; i++) begin
         a_en = toggle ? (i % 2 == 0) : 1'b1;
         step();
         if (a_stb) begin
            a_q.push_back(beat(a_de, a_hs, a_vs, a_x, a_y));
            if (prev) a_consec++;
            if (drop_run) a_run = 1'b0;
            if (a_hs)      begin rx_x = 0; rx_y++; end
            else if (a_vs) begin rx_x = 0; rx_y = 0; rx_f++; end
            else           rx_x++;
         end
         prev = a_stb;
      end
      a_en = 1'b1;
   endtask

   task automatic cmp_seq_a(input string tag);
      check({tag, "_count"}, a_q.size(), 11);
      for (int i = 0; i < 11; i++)
         check($sformatf("%s_beat%0d", tag, i), (i < a_q.size()) ? a_q[i] : 32'hFFFFFFFF, exp_a[i]);
   endtask

   // Measure instance B: cycles between two vsync beats, beats in that window, frame at each vsync.
   task automatic measure_b(input bit toggle, output int period, output int nbeats,
                            output logic [31:0] fr1, output logic [31:0] fr2);
      int t1, t2;
      t1 = -1; t2 = -1; nbeats = 0; fr1 = '0; fr2 = '0;
      for (int i = 0; i < 100; i++) begin
         b_en = toggle ? (i % 2 == 0) : 1'b1;
         step();
         if (b_stb && b_vs) begin
            if (t1 < 0) begin t1 = i; fr1 = b_frame; end
            else if (t2 < 0) begin t2 = i; fr2 = b_frame; end
         end
         if (b_stb && t1 >= 0 && i > t1 && (t2 < 0 || i == t2)) nbeats++;
      end
      b_en = 1'b1;
      period = (t1 >= 0 && t2 >= 0) ? t2 - t1 : -1;
   endtask

   initial begin
      int period, nbeats, both;
      logic [31:0] fr1, fr2;
      logic [31:0] c_q[$];
      bit found;

      a_rst_n = 1'b0; a_en = 1'b0; a_run = 1'b0;
      b_rst_n = 1'b0; b_en = 1'b0; b_run = 1'b0;
      c_rst_n = 1'b0; c_en = 1'b0; c_run = 1'b0;
      #2;
      check("reset_flags", {27'd0, a_stb, a_hs, a_vs, a_de, a_busy}, 32'd0);
      check("reset_x", a_x, 32'd0);
      check("reset_y", a_y, 32'd0);
      check("reset_frame", a_frame, 32'd0);
      #1;
      a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;

      // One frame, run dropped during row 0.
      a_run = 1'b1;
      collect_a(20, 1'b0, 1'b1);
      cmp_seq_a("frame1");
      check("frame1_frame", a_frame, 32'd1);
      check("frame1_busy", {31'd0, a_busy}, 32'd0);
      check("rx_x", rx_x, 0);
      check("rx_y", rx_y, 0);
      check("rx_frame", rx_f, 1);

      // Restart with en toggling; same order, frame continues from 1.
      a_run = 1'b1;
      collect_a(30, 1'b1, 1'b1);
      cmp_seq_a("toggle");
      check("toggle_consec_stb", a_consec, 0);
      check("toggle_frame", a_frame, 32'd2);
      check("toggle_busy", {31'd0, a_busy}, 32'd0);

      // Async reset in mid-row at x=2.
      a_run = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (a_stb && a_de && a_x == 32'd2) begin found = 1'b1; break; end
      end
      check("rst_found_x2", {31'd0, found}, 32'd1);
      #2;
      a_rst_n = 1'b0;
      #1;
      check("rst_async_flags", {27'd0, a_stb, a_hs, a_vs, a_de, a_busy}, 32'd0);
      check("rst_async_x", a_x, 32'd0);
      check("rst_async_frame", a_frame, 32'd0);
      #1;
      a_rst_n = 1'b1;
      step();
      check("rst_first_edge_stb", {31'd0, a_stb}, 32'd0);
      step();
      check("rst_first_pixel", beat(a_de, a_hs, a_vs, a_x, a_y), 32'h10000);
      check("rst_first_frame", a_frame, 32'd0);
      a_run = 1'b0;

      // Blanked instance: continuous run, then with en toggling.
      b_run = 1'b1;
      measure_b(1'b0, period, nbeats, fr1, fr2);
      check("blank_period", period, 15);
      check("blank_beats", nbeats, 11);
      check("blank_frame_v1", fr1, 32'd1);
      check("blank_frame_v2", fr2, 32'd2);
      measure_b(1'b1, period, nbeats, fr1, fr2);
      check("blank_toggle_period", period, 30);
      check("blank_toggle_beats", nbeats, 11);
      check("blank_toggle_frame_step", fr2, fr1 + 32'd1);

      // 1x1 frame: px, H, V repeating.
      c_run = 1'b1; c_en = 1'b1;
      both = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (c_stb) c_q.push_back(beat(c_de, c_hs, c_vs, c_x, c_y));
         if (c_hs && c_vs) both++;
      end
      check("tiny_count", c_q.size(), 9);
      for (int i = 0; i < 9; i++)
         check($sformatf("tiny_beat%0d", i), (i < c_q.size()) ? c_q[i] : 32'hFFFFFFFF, exp_c[i]);
      check("tiny_no_hv_overlap", both, 0);
      check("tiny_frame", c_frame, 32'd3);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
